// File: rtl/channel_arbiter_8.sv
// Eight-requester channel arbiter with hold-timeout preemption.
// Define CHANNEL_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority (highest index wins).
module channel_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned IW   = 3;
    localparam int unsigned CW   = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   id_q, id_d;
    logic            valid_q, valid_d;
    logic            preempt_q, preempt_d;
    logic [IW-1:0]   sel_id;
    logic            sel_hit;
`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx;
`endif

    // Requester selection: round-robin searches downward from the last grant, otherwise highest index wins
    always_comb begin
        sel_id  = '0;
        sel_hit = 1'b0;
`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
        idx = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            idx = IW'(ptr_q - IW'(i));
            if (!sel_hit && req[idx]) begin
                sel_hit = 1'b1;
                sel_id  = idx;
            end
        end
`else
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req[i]) begin
                sel_id = IW'(i);
            end
        end
        sel_hit = |req;
`endif
    end

    // Next-state and registered-output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        preempt_d = 1'b0;
`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_hit) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    gnt_d   = NREQ'(1) << sel_id;
                    id_d    = sel_id;
`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
                    ptr_d   = sel_id;
`endif
                end
            end
            BUSY: begin
                // Release takes precedence over a simultaneous timeout
                if (done || !req[id_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    id_d    = '0;
                end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    id_d      = '0;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase
        valid_d = (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_channel_arbiter_8.sv
// Directed scoreboard bench for channel_arbiter_8 with MAX_HOLD = 4.
// Expectations follow the build: CHANNEL_ARB_ROUND_ROBIN_EN selects round-robin expectations.
module tb_channel_arbiter_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic       preempt;
    } exp_t;

    exp_t sb[$];

`ifdef CHANNEL_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    channel_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] enc(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] eg, input logic ep);
        chk({tag, ".gnt"},       gnt,              eg);
        chk({tag, ".gnt_id"},    8'(gnt_id),       8'(enc(eg)));
        chk({tag, ".gnt_valid"}, 8'(gnt_valid),    8'(|eg));
        chk({tag, ".preempt"},   8'(preempt),      8'(ep));
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, then compare
    task automatic cyc(input string tag, input logic [7:0] r, input logic d,
                       input logic [7:0] eg, input logic ep);
        exp_t e;
        req  = r;
        done = d;
        e.tag = tag; e.gnt = eg; e.preempt = ep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(e.tag, e.gnt, e.preempt);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc("idle_noreq", 8'h00, 1'b0, 8'h00, 1'b0);
        cyc("first_gnt",  8'h24, 1'b0, 8'h20, 1'b0);
        cyc("done_rel",   8'h24, 1'b1, 8'h00, 1'b0);
        cyc("next_gnt",   8'h24, 1'b0, RR ? 8'h04 : 8'h20, 1'b0);
        cyc("req_drop",   8'h00, 1'b0, 8'h00, 1'b0);
        cyc("idle_done",  8'h00, 1'b1, 8'h00, 1'b0);
        cyc("idle_quiet", 8'h00, 1'b0, 8'h00, 1'b0);

        // Hold timeout: grant visible exactly 4 cycles, then a preempt pulse
        for (int i = 0; i < 4; i++) cyc("hold", 8'h08, 1'b0, 8'h08, 1'b0);
        cyc("timeout",    8'h08, 1'b0, 8'h00, 1'b1);
        cyc("regrant",    8'h08, 1'b0, 8'h08, 1'b0);
        cyc("regrant_rel",8'h08, 1'b1, 8'h00, 1'b0);

        // Release coinciding with the timeout cycle wins
        for (int i = 0; i < 4; i++) cyc("hold2", 8'h08, 1'b0, 8'h08, 1'b0);
        cyc("rel_vs_to",  8'h08, 1'b1, 8'h00, 1'b0);
        cyc("rel_vs_to2", 8'h00, 1'b0, 8'h00, 1'b0);

        // Other requesters cannot disturb the holder
        cyc("hold4",      8'h10, 1'b0, 8'h10, 1'b0);
        cyc("stable4",    8'hF0, 1'b0, 8'h10, 1'b0);
        cyc("rel4",       8'hF0, 1'b1, 8'h00, 1'b0);
        cyc("idle4",      8'h00, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset during a grant
        cyc("hold6",      8'h40, 1'b0, 8'h40, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_held", 8'h00, 1'b0);
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;

        // Full request: rotation under round-robin, always 7 under fixed priority
        for (int i = 0; i < 9; i++) begin
            logic [7:0] eg;
            eg = RR ? (8'h80 >> (i % 8)) : 8'h80;
            cyc("rot_gnt", 8'hFF, 1'b0, eg, 1'b0);
            cyc("rot_rel", 8'hFF, 1'b1, 8'h00, 1'b0);
        end
        cyc("end_idle", 8'h00, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_arbiter_8.md
CHANNEL_ARBITER_8 -- requirements
Module: channel_arbiter_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles a grant is held before forced release (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 8, per-requester request, bit i = requester i.
REQ-005 The block SHALL have port done, input, 1, pulse from the current holder releasing the channel.
REQ-006 The block SHALL have port gnt, output, 8, one-hot grant, registered.
REQ-007 The block SHALL have port gnt_id, output, 3, binary index of the granted requester, registered.
REQ-008 The block SHALL have port gnt_valid, output, 1, high while any grant is held, registered.
REQ-009 The block SHALL have port preempt, output, 1, one-cycle pulse on a forced release by hold timeout.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 IDLE with req != 0 at edge N SHALL move to BUSY, with gnt/gnt_id/gnt_valid valid from edge N (visible cycle N+1); req == 0 SHALL remain IDLE.
REQ-012 gnt SHALL be one-hot or zero at all times; gnt_valid SHALL equal |gnt; gnt_id SHALL equal the encoded index of gnt, or 0 when gnt == 0.
REQ-013 In BUSY, grant, gnt_id and holder SHALL remain stable; req changes from other requesters SHALL have no effect.
REQ-014 In BUSY, done = 1 or req[gnt_id] = 0 SHALL return to IDLE with gnt = 0 at the next edge; earliest new grant is one edge later (one-cycle gap).
REQ-015 A 8-bit hold counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-016 When the counter reaches MAX_HOLD-1 without release, the next edge SHALL clear the grant, return to IDLE and assert preempt for exactly one cycle.
REQ-017 If release (REQ-014) and timeout occur in the same cycle, release SHALL win: no preempt.
REQ-018 done asserted while IDLE SHALL be ignored.
REQ-019 Requester selection SHALL be determined by the selection policy in REQ-024/REQ-025.
REQ-020 A preempted requester still requesting SHALL be arbitrated normally in IDLE.

Reset
REQ-021 rst_n low SHALL immediately force gnt = 0, gnt_id = 0, gnt_valid = 0, preempt = 0, state IDLE, hold counter 0, last-grant pointer 0, independent of clk.
REQ-022 Reset asserted during BUSY SHALL drop the grant without a preempt pulse.
REQ-023 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-024 With macro CHANNEL_ARB_ROUND_ROBIN_EN defined, selection SHALL be round-robin: with last-granted index k, search order k-1, k-2, ..., 0, 7, ..., k (wrapping), first set req bit wins; pointer updates to the new grant index on every grant, including one ended by preempt.
REQ-025 Without CHANNEL_ARB_ROUND_ROBIN_EN, selection SHALL be fixed priority, highest index wins; no pointer register shall exist.
REQ-026 With pointer reset to 0, the first round-robin search order SHALL be 7..0, identical to fixed priority.

Verification
REQ-027 Reset release, req = 8'b0010_0100 -> one cycle later gnt = 8'b0010_0000, gnt_id = 5, gnt_valid = 1.
REQ-028 Holder 5, done pulsed at cycle M -> gnt = 0 at M+1; with req = 8'b0010_0100 still asserted, RR build gives gnt_id = 2 at M+2, fixed build gives gnt_id = 5.
REQ-029 MAX_HOLD = 4, req[3] held, no done -> gnt_valid high exactly 4 cycles, then gnt = 0 with preempt = 1 for one cycle.
REQ-030 MAX_HOLD = 4, done pulsed in the timeout cycle -> gnt = 0 next cycle, preempt stays 0.
REQ-031 Holder 6 in BUSY, rst_n pulsed low mid-cycle -> gnt, gnt_id, gnt_valid go 0 before the next edge; preempt stays 0.
REQ-032 RR build, req = 8'hFF held, done pulsed each grant -> gnt_id sequence 7, 6, 5, 4, 3, 2, 1, 0, 7.
